spike_decoder: RTL and testbench
================================

# spike_decoder

Receive-side counterpart of the oscillator neuron: consumes a synchronous spike train and measures the inter-spike interval (ISI) in clock cycles. Each measured interval goes to a downstream consumer over a valid/ready stream. The block flags loss of spiking activity (timeout) and a stable period (lock). It sits between neuron spike outputs and network coupling/readout logic.

## Interface
- CNT_W, 8: width of interval counter and isi_data.
- TIMEOUT, 200: cycles without a spike before LOST; legal range 2..2^CNT_W-1.
- FIFO_DEPTH, 4: output buffer depth, power of 2, ≥2; used only with SPIKE_DECODER_FIFO_EN.

- clk  input  1  clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  measurement enable; low forces IDLE.
- spike_in  input  1  spike train, synchronous to clk, any high width.
- isi_data  output  CNT_W  measured interval in cycles.
- isi_valid  output  1  isi_data holds an unconsumed interval.
- isi_ready  input  1  consumer accepts when high with isi_valid.
- locked  output  1  last two emitted intervals equal.
- timeout  output  1  high while in LOST.
- overflow  output  1  one-cycle pulse when an interval is dropped on full buffer.

## Operation
- Edge detect: spk_prev registers spike_in. A rise is spike_in & ~spk_prev in the same cycle. A high level of any length counts as one spike. spk_prev resets to 0.
- States:
  - IDLE: cnt=0. On rise → MEASURE, cnt←1, nothing emitted.
  - MEASURE: each cycle without a rise, cnt←cnt+1.
    - Rise: push cnt as interval, cnt←1, stay.
    - No rise and cnt==TIMEOUT: → LOST, cnt held.
    - Rise with cnt==TIMEOUT: the rise wins; push TIMEOUT, stay in MEASURE.
  - LOST: timeout=1. On rise → MEASURE, cnt←1, nothing emitted.
- Interval definition: rises at cycles t and t+N yield isi_data=N. A neuron spiking every 5 cycles yields 5.
- cnt never exceeds TIMEOUT, so it cannot wrap.
- Lock:
  - last_isi holds the previous pushed value, including pushes that were dropped.
  - Set locked when a new interval equals last_isi and last_isi is valid.
  - Clear locked on an unequal interval, on entry to LOST, or when enable is low.
- enable low: state←IDLE, cnt←0, locked←0, last_isi invalidated. The buffer keeps its contents and remains drainable.
- Handshake:
  - Transfer occurs when isi_valid & isi_ready.
  - isi_data is stable while isi_valid=1 and no transfer.
  - isi_valid=0 when the buffer is empty.
- Full buffer:
  - A push with no pop drops the new interval and pulses overflow for 1 cycle.
  - A push and pop in the same cycle with the buffer full is accepted with no drop.
- Reset: state IDLE, cnt=0, buffer empty. Outputs isi_data=0, isi_valid=0, locked=0, timeout=0, overflow=0.

## Timing
- Push occurs at the clock edge ending the rise cycle. isi_valid=1 in the next cycle: 1-cycle latency.
- locked updates at the same edge as the push. timeout rises the cycle after cnt==TIMEOUT with no rise.
- Pop and push in the same cycle are both performed. Occupancy is unchanged and FIFO order is preserved.
- Asynchronous reset takes effect immediately and clears any in-progress measurement. The first rise after release is treated as from IDLE.

## Configuration
- SPIKE_DECODER_FIFO_EN defined: output buffer is a FIFO of FIFO_DEPTH entries with wrap-around read/write pointers and a full/empty occupancy count.
- Not defined: buffer is a single holding register (depth 1). FIFO_DEPTH is ignored. Full means isi_valid=1; the same drop and simultaneous push/pop rules apply.

## Test plan
- 1-cycle spikes every 5 cycles, isi_ready=1:
  - First rise emits nothing.
  - Each later rise yields isi_data=5, isi_valid for 1 cycle, 1 cycle after the rise.
  - locked=1 from the second emitted interval.
- spike_in held high 3 cycles, repeated every 8 cycles: isi_data=8 each time, never a 1-cycle interval.
- One spike, then silence: timeout=1 at 201 cycles after the rise, locked=0. The next rise emits nothing; the following rise 6 cycles later emits 6.
- isi_ready=0, six spikes 5 apart giving five intervals:
  - With macro: four 5s buffered, fifth dropped with an overflow pulse; then drain four entries in order.
  - Without macro: one buffered, four overflow pulses.
- Intervals 5,5,7,7: locked rises after the second 5, falls with the 7, rises again with the second 7.
- reset low mid-MEASURE with 2 entries buffered: isi_valid, locked, timeout, overflow and isi_data all 0 immediately. After release, the first rise emits nothing.

Source files
------------

// File: rtl/spike_decoder_if.sv
// -----------------------------------------------------------------------------
// spike_decoder_if
// Valid/ready stream that carries measured inter-spike intervals from
// spike_decoder (master) to a downstream consumer (slave).
//
// Signals:
//   isi_data   master->slave  CNT_W  measured interval in clock cycles
//   isi_valid  master->slave  1      isi_data holds an unconsumed interval
//   isi_ready  slave->master  1      consumer accepts when high with isi_valid
// -----------------------------------------------------------------------------
interface spike_decoder_if #(
    parameter int CNT_W = 8
);
    logic [CNT_W-1:0] isi_data;
    logic             isi_valid;
    logic             isi_ready;

    modport master (
        output isi_data,
        output isi_valid,
        input  isi_ready
    );

    modport slave (
        input  isi_data,
        input  isi_valid,
        output isi_ready
    );
endinterface

// File: rtl/spike_decoder.sv
// -----------------------------------------------------------------------------
// spike_decoder
// Measures the inter-spike interval (ISI) of a synchronous spike train in
// clock cycles and streams each interval to a consumer. Flags loss of
// activity (timeout) and a stable period (locked).
//
// Build option:
//   SPIKE_DECODER_FIFO_EN  defined   -> output buffer is a FIFO_DEPTH-entry FIFO
//                          undefined -> output buffer is one holding register
//
// Ports:
//   i_clk       in   clock, rising edge
//   i_rst_n     in   asynchronous active-low reset
//   i_enable    in   measurement enable; low forces IDLE and drops lock history
//   i_spike_in  in   spike train, any high width counts as one spike
//   isi_bus     if   master side of the interval stream (data/valid/ready)
//   o_locked    out  last two pushed intervals were equal
//   o_timeout   out  high while no spike has been seen for more than TIMEOUT
//   o_overflow  out  one-cycle pulse when an interval is dropped on full buffer
//
// States:
//   IDLE    | no reference spike yet, cnt = 0
//   MEASURE | counting cycles since the last rising edge of the spike train
//   LOST    | no spike for TIMEOUT cycles, waiting to restart
// -----------------------------------------------------------------------------
module spike_decoder #(
    parameter int CNT_W      = 8,
    parameter int TIMEOUT    = 200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_enable,
    input  logic                   i_spike_in,
    spike_decoder_if.master        isi_bus,
    output logic                   o_locked,
    output logic                   o_timeout,
    output logic                   o_overflow
);

    if (TIMEOUT < 2 || TIMEOUT > (2 ** CNT_W) - 1 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("spike_decoder: illegal TIMEOUT or FIFO_DEPTH");
    end

    localparam logic [CNT_W-1:0] TMO = TIMEOUT[CNT_W-1:0];
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_LOST    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_spk_prev;
    logic             w_rise;
    logic             w_push;
    logic             w_lost_entry;

    logic [CNT_W-1:0] r_last_isi;
    logic             r_last_ok;
    logic             r_locked;
    logic             r_overflow;

    logic             w_valid;
    logic             w_full;
    logic             w_pop;
    logic             w_accept;
    logic [CNT_W-1:0] w_rd_data;

    // A high level of any length is one spike: only the rising edge counts.
    assign w_rise = i_spike_in & ~r_spk_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_spk_prev <= 1'b0;
        end else begin
            r_spk_prev <= i_spike_in;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_push       = 1'b0;
        w_lost_entry = 1'b0;
        if (!i_enable) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_cnt_nxt = '0;
                    if (w_rise) begin
                        w_state_nxt = S_MEASURE;
                        w_cnt_nxt   = ONE;
                    end
                end
                S_MEASURE: begin
                    // A rise on the TIMEOUT cycle still counts as a valid interval.
                    if (w_rise) begin
                        w_push    = 1'b1;
                        w_cnt_nxt = ONE;
                    end else if (r_cnt == TMO) begin
                        w_state_nxt  = S_LOST;
                        w_lost_entry = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + ONE;
                    end
                end
                S_LOST: begin
                    if (w_rise) begin
                        w_state_nxt = S_MEASURE;
                        w_cnt_nxt   = ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Lock history tracks every pushed interval, even ones the buffer drops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_isi <= '0;
            r_last_ok  <= 1'b0;
            r_locked   <= 1'b0;
        end else if (!i_enable) begin
            r_last_ok <= 1'b0;
            r_locked  <= 1'b0;
        end else if (w_push) begin
            r_locked   <= r_last_ok && (r_cnt == r_last_isi);
            r_last_isi <= r_cnt;
            r_last_ok  <= 1'b1;
        end else if (w_lost_entry) begin
            r_locked <= 1'b0;
        end
    end

    assign w_pop    = w_valid & isi_bus.isi_ready;
    // When full, a simultaneous pop frees the slot the push needs.
    assign w_accept = w_push & (~w_full | w_pop);

`ifdef SPIKE_DECODER_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_L = FIFO_DEPTH[PTR_W:0];

    logic [CNT_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;

    assign w_full    = (r_count == DEPTH_L);
    assign w_valid   = (r_count != '0);
    assign w_rd_data = r_mem[r_rptr];

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_mem[r_wptr] <= r_cnt;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
`else
    logic [CNT_W-1:0] r_hold;
    logic             r_hold_valid;

    assign w_full    = r_hold_valid;
    assign w_valid   = r_hold_valid;
    assign w_rd_data = r_hold;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else if (w_accept) begin
            r_hold       <= r_cnt;
            r_hold_valid <= 1'b1;
        end else if (w_pop) begin
            r_hold_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_push & ~w_accept;
        end
    end

    // Data is forced to zero while empty so reset and idle look identical.
    assign isi_bus.isi_data  = w_valid ? w_rd_data : '0;
    assign isi_bus.isi_valid = w_valid;
    assign o_locked          = r_locked;
    assign o_timeout         = (r_state == S_LOST);
    assign o_overflow        = r_overflow;

endmodule

// File: tb/tb_spike_decoder.sv
module tb_spike_decoder;

    localparam int CNT_W      = 8;
    localparam int TIMEOUT    = 200;
    localparam int FIFO_DEPTH = 4;
`ifdef SPIKE_DECODER_FIFO_EN
    localparam int CAP = FIFO_DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic clk;
    logic i_rst_n;
    logic i_enable;
    logic i_spike_in;
    logic o_locked;
    logic o_timeout;
    logic o_overflow;

    spike_decoder_if #(.CNT_W(CNT_W)) isi ();

    spike_decoder #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (i_rst_n),
        .i_enable   (i_enable),
        .i_spike_in (i_spike_in),
        .isi_bus    (isi),
        .o_locked   (o_locked),
        .o_timeout  (o_timeout),
        .o_overflow (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: time stamps of rising edges and a queue of intervals.
    int  m_cyc;
    bit  m_prev;
    bit  m_started;
    int  m_last_rise;
    int  q[$];
    int  m_last_isi;
    bit  m_last_ok;
    bit  m_locked;
    bit  m_ovf;
    bit  m_tmo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, m_cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev      = 1'b0;
        m_started   = 1'b0;
        m_last_rise = 0;
        q.delete();
        m_last_isi  = 0;
        m_last_ok   = 1'b0;
        m_locked    = 1'b0;
        m_ovf       = 1'b0;
        m_tmo       = 1'b0;
    endtask

    task automatic check_outputs();
        chk("isi_valid", {31'd0, isi.isi_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
        chk("isi_data",  {24'd0, isi.isi_data},  (q.size() > 0) ? q[0] : 0);
        chk("locked",    {31'd0, o_locked},      {31'd0, m_locked});
        chk("timeout",   {31'd0, o_timeout},     {31'd0, m_tmo});
        chk("overflow",  {31'd0, o_overflow},    {31'd0, m_ovf});
    endtask

    // One clock cycle: drive inputs at the falling edge, predict, check at next falling edge.
    task automatic cycle(input bit spk, input bit rdy, input bit en = 1'b1);
        bit rise;
        bit push;
        bit pop;
        int val;
        int pre;
        i_spike_in    = spk;
        isi.isi_ready = rdy;
        i_enable      = en;
        rise = spk && !m_prev;
        push = 1'b0;
        val  = 0;
        m_ovf = 1'b0;
        if (!en) begin
            m_started = 1'b0;
            m_locked  = 1'b0;
            m_last_ok = 1'b0;
        end else if (rise) begin
            if (m_started && (m_cyc - m_last_rise) <= TIMEOUT) begin
                push = 1'b1;
                val  = m_cyc - m_last_rise;
            end
            m_started   = 1'b1;
            m_last_rise = m_cyc;
        end
        if (push) begin
            m_locked   = m_last_ok && (val == m_last_isi);
            m_last_isi = val;
            m_last_ok  = 1'b1;
        end
        pre = q.size();
        pop = (pre > 0) && rdy;
        if (pop) void'(q.pop_front());
        if (push) begin
            if (pre < CAP || pop) q.push_back(val);
            else m_ovf = 1'b1;
        end
        m_prev = spk;
        m_cyc++;
        m_tmo = m_started && ((m_cyc - m_last_rise) > TIMEOUT);
        if (m_tmo) m_locked = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic spikes(input int period, input int width, input int n, input bit rdy);
        for (int s = 0; s < n; s++) begin
            for (int c = 0; c < period; c++) begin
                cycle(c < width, rdy);
            end
        end
    endtask

    // First rise, then one rise after each listed gap.
    task automatic gaps(input int g0, input int g1, input int g2, input int g3, input bit rdy);
        int g[4];
        g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;
        cycle(1'b1, rdy);
        for (int k = 0; k < 4; k++) begin
            if (g[k] > 0) begin
                repeat (g[k] - 1) cycle(1'b0, rdy);
                cycle(1'b1, rdy);
            end
        end
    endtask

    task automatic clean();
        repeat (2) cycle(1'b0, 1'b1, 1'b0);
        repeat (CAP + 1) cycle(1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        int per;
        int wid;
        i_rst_n       = 1'b0;
        i_enable      = 1'b1;
        i_spike_in    = 1'b0;
        isi.isi_ready = 1'b1;
        m_cyc = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        i_rst_n = 1'b1;

        // 1-cycle spikes every 5 cycles, consumer always ready.
        spikes(5, 1, 5, 1'b1);
        // Wide pulses: 3 high, period 8.
        spikes(8, 3, 5, 1'b1);
        repeat (3) cycle(1'b0, 1'b1);

        // Loss of activity and restart.
        clean();
        cycle(1'b1, 1'b1);
        repeat (205) cycle(1'b0, 1'b1);
        gaps(6, 0, 0, 0, 1'b1);
        repeat (3) cycle(1'b0, 1'b1);

        // Rise exactly on the TIMEOUT cycle still emits TIMEOUT.
        clean();
        gaps(TIMEOUT, 0, 0, 0, 1'b1);
        repeat (TIMEOUT + 2) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        repeat (3) cycle(1'b0, 1'b1);

        // Stalled consumer: overflow behaviour, then drain in order.
        clean();
        spikes(5, 1, 6, 1'b0);
        repeat (FIFO_DEPTH + 2) cycle(1'b0, 1'b1);

        // Full buffer with simultaneous pop and push.
        clean();
        spikes(5, 1, CAP + 2, 1'b0);
        cycle(1'b1, 1'b1);
        repeat (FIFO_DEPTH + 2) cycle(1'b0, 1'b1);

        // Lock sequence 5,5,7,7.
        clean();
        gaps(5, 5, 7, 7, 1'b1);
        repeat (3) cycle(1'b0, 1'b1);

        // enable low mid-stream keeps buffered data drainable.
        clean();
        gaps(4, 4, 0, 0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        repeat (CAP + 1) cycle(1'b0, 1'b1, 1'b0);
        gaps(3, 0, 0, 0, 1'b1);

        // Asynchronous reset mid-measurement with data buffered and lock set.
        clean();
        gaps(5, 5, 0, 0, 1'b0);
        repeat (2) cycle(1'b0, 1'b0);
        #2;
        i_rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        i_rst_n = 1'b1;
        gaps(5, 5, 0, 0, 1'b1);
        repeat (3) cycle(1'b0, 1'b1);

        // Random periodic trains with random ready.
        for (int k = 0; k < 8; k++) begin
            per = $urandom_range(2, 20);
            wid = $urandom_range(1, per - 1);
            spikes(per, wid, 4, 1'($urandom_range(0, 1)));
        end

        // Fully random spikes, ready and enable.
        for (int k = 0; k < 600; k++) begin
            cycle(($urandom_range(0, 99) < 25), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) >= 3));
        end
        repeat (FIFO_DEPTH + 2) cycle(1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
